axi4_mem_responder: RTL

AXI4 slave memory that terminates the master port of the chipset NoC-to-AXI4 memory bridge. It accepts write and read bursts and stores data in an internal byte-writable array. The same `m_axi_*` bundle the memory controller would otherwise serve connects here directly. It serves as a synthesizable on-chip memory target and as the reference responder for bridge simulation.

---
 rtl/axi4_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave backed by a byte-writable word array.
// Independent read and write FSMs, one transaction each; FIXED and INCR bursts only.
module axi4_mem_responder #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned ID_WIDTH       = 6,
  parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned DEPTH    = 2 ** MEM_DEPTH_LOG2;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [MEM_DEPTH_LOG2-1:0] aw_idx_c;
  logic [MEM_DEPTH_LOG2-1:0] ar_idx_c;
  assign aw_idx_c = s_axi_awaddr[ADDR_LSB +: MEM_DEPTH_LOG2];
  assign ar_idx_c = s_axi_araddr[ADDR_LSB +: MEM_DEPTH_LOG2];

  // Size and the aliased upper address bits carry no meaning here.
  logic unused_sigs;
  assign unused_sigs = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr, s_axi_araddr};

  // ---------------- write side ----------------
  w_state_e                  w_state_q, w_state_d;
  logic [MEM_DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
  logic [7:0]                w_len_q, w_len_d;
  logic [8:0]                w_cnt_q, w_cnt_d;
  logic                      w_incr_q, w_incr_d;
  logic                      w_ok_q, w_ok_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]       bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      mem_we_c;
  logic [DATA_WIDTH-1:0]     wmask_c;

  for (genvar b = 0; b < STRB_W; b++) begin : g_wmask
    assign wmask_c[b*8 +: 8] = {8{s_axi_wstrb[b]}};
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_incr_d  = w_incr_q;
    w_ok_d    = w_ok_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          bid_d     = s_axi_awid;
          w_idx_d   = aw_idx_c;
          w_len_d   = s_axi_awlen;
          w_incr_d  = (s_axi_awburst == BURST_INCR);
          w_ok_d    = burst_ok(s_axi_awburst);
          w_cnt_d   = '0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          // Beats past awlen+1 are still counted so the length error is reported.
          mem_we_c = w_ok_q && (w_cnt_q <= {1'b0, w_len_q});
          if (w_cnt_q != 9'h1FF) w_cnt_d = w_cnt_q + 9'd1;
          if (w_incr_q) w_idx_d = w_idx_q + MEM_DEPTH_LOG2'(1);
          if (s_axi_wlast) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (!w_ok_q || (w_cnt_q != {1'b0, w_len_q})) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_incr_q  <= 1'b0;
      w_ok_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_incr_q  <= w_incr_d;
      w_ok_q    <= w_ok_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-masked read-modify-write of the addressed word; the array has no reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[w_idx_q] <= (mem_q[w_idx_q] & ~wmask_c) | (s_axi_wdata & wmask_c);
  end

  // ---------------- read side ----------------
  r_state_e                  r_state_q, r_state_d;
  logic [MEM_DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
  logic [7:0]                r_len_q, r_len_d;
  logic [7:0]                r_beat_q, r_beat_d;
  logic                      r_incr_q, r_incr_d;
  logic                      r_ok_q, r_ok_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]       rid_q, rid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [MEM_DEPTH_LOG2-1:0] r_idx_nxt_c;
  logic [MEM_DEPTH_LOG2-1:0] rd_idx_c;
  logic [DATA_WIDTH-1:0]     rd_word_c;

  // Data is captured once, when a beat is first presented, so stalls hold it stable.
  assign r_idx_nxt_c = r_incr_q ? r_idx_q + MEM_DEPTH_LOG2'(1) : r_idx_q;
  assign rd_idx_c    = (r_state_q == R_IDLE) ? ar_idx_c : r_idx_nxt_c;
  assign rd_word_c   = mem_q[rd_idx_c];

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_incr_d  = r_incr_q;
    r_ok_d    = r_ok_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          r_idx_d   = ar_idx_c;
          r_len_d   = s_axi_arlen;
          r_beat_d  = '0;
          r_incr_d  = (s_axi_arburst == BURST_INCR);
          r_ok_d    = burst_ok(s_axi_arburst);
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (s_axi_arlen == 8'd0);
          rid_d     = s_axi_arid;
          rresp_d   = burst_ok(s_axi_arburst) ? RESP_OKAY : RESP_SLVERR;
          rdata_d   = burst_ok(s_axi_arburst) ? rd_word_c : '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            r_idx_d  = r_idx_nxt_c;
            rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
            rdata_d  = r_ok_q ? rd_word_c : '0;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_incr_q  <= 1'b0;
      r_ok_q    <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_incr_q  <= r_incr_d;
      r_ok_q    <= r_ok_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

endmodule
